mult_rc_multi: RTL and testbench

MULT_RC_MULTI -- requirements
Module: mult_rc_multi

---
 rtl/mult_rc_multi_pkg.sv | 8 +
 rtl/mult_rc_lane.sv | 85 ++++++++
 rtl/mult_rc_multi.sv | 84 ++++++++
 tb/tb_mult_rc_multi.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_rc_multi_pkg.sv
// mult_rc_multi_pkg: shared constants and helpers for the real-by-complex multiplier
package mult_rc_multi_pkg;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mult_rc_lane.sv
// mult_rc_lane: one complex lane scaled by a real operand with round/shift/clip
module mult_rc_lane
  import mult_rc_multi_pkg::*;
#(
  parameter int WIDTH_REAL = 16,
  parameter int WIDTH_CPLX = 16,
  parameter int LATENCY    = 3,
  parameter int WIDTH_OUT  = 16,
  parameter int SHIFT      = 15,
  parameter int ROUND      = 1,
  parameter int CLIP       = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [WIDTH_REAL-1:0]    real_i,
  input  logic [2*WIDTH_CPLX-1:0]  cplx_i,
  output logic [2*WIDTH_OUT-1:0]   p_o,
  output logic                     clip_o
);
  localparam int PW = WIDTH_REAL + WIDTH_CPLX;
  localparam int EW = max_i(PW + 1, WIDTH_OUT + 1);
  localparam int RS = LATENCY > 1 ? LATENCY - 1 : 1;
  localparam logic signed [EW-1:0] SAT_MAX = (EW'(1) << (WIDTH_OUT - 1)) - EW'(1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [EW-1:0] RND = (ROUND != 0 && SHIFT > 0) ? EW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;

  logic signed [PW-1:0] pi_d, pq_d, pi_s, pq_s;
  logic [WIDTH_OUT-1:0] vi, vq;
  logic fi, fq;
  logic [2*WIDTH_OUT-1:0] res_d [RS];
  logic [2*WIDTH_OUT-1:0] res_q [RS];

  // Widened sum keeps the rounding constant from overflowing the most positive product
  function automatic logic [WIDTH_OUT:0] scale(input logic signed [PW-1:0] p);
    logic signed [EW-1:0] s;
    logic f;
    s = (EW'(p) + RND) >>> SHIFT;
    f = CLIP != 0 && (s > SAT_MAX || s < SAT_MIN);
    return {f, f ? (s > SAT_MAX ? SAT_MAX[WIDTH_OUT-1:0] : SAT_MIN[WIDTH_OUT-1:0]) : s[WIDTH_OUT-1:0]};
  endfunction

  // Full-precision I*real and Q*real products
  always_comb begin
    pi_d = PW'($signed(real_i)) * PW'($signed(cplx_i[2*WIDTH_CPLX-1:WIDTH_CPLX]));
    pq_d = PW'($signed(real_i)) * PW'($signed(cplx_i[WIDTH_CPLX-1:0]));
  end

  if (LATENCY > 1) begin : g_preg
    logic signed [PW-1:0] pi_q, pq_q;
    // Multiplier output register, first pipeline stage
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        pi_q <= '0;
        pq_q <= '0;
      end else if (en) begin
        pi_q <= pi_d;
        pq_q <= pq_d;
      end
    assign pi_s = pi_q;
    assign pq_s = pq_q;
  end else begin : g_nopreg
    assign pi_s = pi_d;
    assign pq_s = pq_d;
  end

  // Scale both components and advance the result delay line
  always_comb begin
    {fi, vi} = scale(pi_s);
    {fq, vq} = scale(pq_s);
    clip_o = fi | fq;
    res_d = res_q;
    if (en) begin
      for (int k = RS - 1; k > 0; k--) res_d[k] = res_q[k-1];
      res_d[0] = {vi, vq};
    end
  end

  // Result pipeline registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) res_q <= '{default: '0};
    else res_q <= res_d;

  assign p_o = res_q[RS-1];
endmodule

// File: rtl/mult_rc_multi.sv
// mult_rc_multi: multi-lane real-by-complex multiplier with AXI-stream handshakes
module mult_rc_multi
  import mult_rc_multi_pkg::*;
#(
  parameter int WIDTH_REAL = 16,
  parameter int WIDTH_CPLX = 16,
  parameter int NUM_CHAN   = 2,
  parameter int LATENCY    = 3,
  parameter int WIDTH_OUT  = 16,
  parameter int SHIFT      = 15,
  parameter int ROUND      = 1,
  parameter int CLIP       = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [WIDTH_REAL-1:0]             real_tdata,
  input  logic                              real_tlast,
  input  logic                              real_tvalid,
  output logic                              real_tready,
  input  logic [NUM_CHAN*2*WIDTH_CPLX-1:0]  cplx_tdata,
  input  logic                              cplx_tlast,
  input  logic                              cplx_tvalid,
  output logic                              cplx_tready,
  output logic [NUM_CHAN*2*WIDTH_OUT-1:0]   p_tdata,
  output logic                              p_tlast,
  output logic                              p_tvalid,
  input  logic                              p_tready,
  input  logic                              clear_count,
  output logic [CNT_W-1:0]                  clip_count
);
  localparam int RS = LATENCY > 1 ? LATENCY - 1 : 1;

  logic stall, en, accept;
  logic [LATENCY-1:0] vld_d, vld_q, last_d, last_q;
  logic [RS-1:0] clip_d, clip_q;
  logic [NUM_CHAN-1:0] lane_clip;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign stall = p_tvalid & ~p_tready;
  assign en = ~stall;
  assign accept = real_tvalid & cplx_tvalid & en;
  assign real_tready = en & cplx_tvalid;
  assign cplx_tready = en & real_tvalid;
  assign p_tvalid = vld_q[LATENCY-1];
  assign p_tlast = last_q[LATENCY-1];
  assign clip_count = cnt_q;

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_lane
    mult_rc_lane #(
      .WIDTH_REAL(WIDTH_REAL), .WIDTH_CPLX(WIDTH_CPLX), .LATENCY(LATENCY),
      .WIDTH_OUT(WIDTH_OUT), .SHIFT(SHIFT), .ROUND(ROUND), .CLIP(CLIP)
    ) u_lane (
      .clk(clk),
      .reset_n(reset_n),
      .en(en),
      .real_i(real_tdata),
      .cplx_i(cplx_tdata[2*WIDTH_CPLX*i +: 2*WIDTH_CPLX]),
      .p_o(p_tdata[2*WIDTH_OUT*i +: 2*WIDTH_OUT]),
      .clip_o(lane_clip[i])
    );
  end

  // Sideband pipelines track the lane data; clip flags join where lanes finish scaling
  always_comb begin
    vld_d = en ? LATENCY'({vld_q, accept}) : vld_q;
    last_d = en ? LATENCY'({last_q, accept & (real_tlast | cplx_tlast)}) : last_q;
    clip_d = en ? RS'({clip_q, |lane_clip}) : clip_q;
    cnt_d = clear_count ? '0 : (p_tvalid && p_tready && clip_q[RS-1] && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  end

  // Sideband and counter registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_q <= '0;
      last_q <= '0;
      clip_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      last_q <= last_d;
      clip_q <= clip_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_mult_rc_multi.sv
// tb_mult_rc_multi: randomized scoreboard bench for mult_rc_multi (round/clip and truncate/wrap builds)
module tb_mult_rc_multi;
  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        c;
  } beat_t;

  logic clk = 0;
  logic reset_n = 0;
  logic [15:0] real_tdata = '0;
  logic real_tlast = 0, real_tvalid = 0, cplx_tlast = 0, cplx_tvalid = 0;
  logic [63:0] cplx_tdata = '0;
  logic p_tready = 1, clear_count = 0;
  logic rr [2], cr [2], pv [2], pl [2];
  logic [63:0] pd [2];
  logic [15:0] cc [2];

  int n_chk = 0, n_fail = 0;
  beat_t q0[$], q1[$];
  logic [15:0] mcnt [2];
  logic prev_st [2];
  logic [63:0] prev_d [2];

  always #5 clk = ~clk;

  mult_rc_multi #(.ROUND(0), .CLIP(0)) dut_t (
    .clk(clk), .reset_n(reset_n),
    .real_tdata(real_tdata), .real_tlast(real_tlast), .real_tvalid(real_tvalid), .real_tready(rr[0]),
    .cplx_tdata(cplx_tdata), .cplx_tlast(cplx_tlast), .cplx_tvalid(cplx_tvalid), .cplx_tready(cr[0]),
    .p_tdata(pd[0]), .p_tlast(pl[0]), .p_tvalid(pv[0]), .p_tready(p_tready),
    .clear_count(clear_count), .clip_count(cc[0])
  );

  mult_rc_multi dut_r (
    .clk(clk), .reset_n(reset_n),
    .real_tdata(real_tdata), .real_tlast(real_tlast), .real_tvalid(real_tvalid), .real_tready(rr[1]),
    .cplx_tdata(cplx_tdata), .cplx_tlast(cplx_tlast), .cplx_tvalid(cplx_tvalid), .cplx_tready(cr[1]),
    .p_tdata(pd[1]), .p_tlast(pl[1]), .p_tvalid(pv[1]), .p_tready(p_tready),
    .clear_count(clear_count), .clip_count(cc[1])
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [16:0] model_comp(input logic [15:0] rv, input logic [15:0] cv, input bit rnd, input bit clp);
    longint p, s;
    p = longint'($signed(rv)) * longint'($signed(cv));
    if (rnd) p = p + 16384;
    s = p >>> 15;
    if (clp && s > 32767) return {1'b1, 16'h7FFF};
    if (clp && s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  function automatic beat_t exp_beat(input logic [15:0] rv, input logic [63:0] cv, input logic l, input bit rnd, input bit clp);
    beat_t b;
    logic [16:0] m;
    b = '0;
    b.l = l;
    for (int k = 0; k < 4; k++) begin
      m = model_comp(rv, cv[16*k +: 16], rnd, clp);
      b.d[16*k +: 16] = m[15:0];
      b.c = b.c | m[16];
    end
    return b;
  endfunction

  task automatic reset_model();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = '0;
      prev_st[k] = 0;
    end
  endtask

  task automatic cycle();
    beat_t e;
    logic st, fire;
    #2;
    for (int k = 0; k < 2; k++) begin
      st = pv[k] & ~p_tready;
      check($sformatf("real_tready%0d", k), 64'(rr[k]), 64'(~st & cplx_tvalid));
      check($sformatf("cplx_tready%0d", k), 64'(cr[k]), 64'(~st & real_tvalid));
      if (prev_st[k]) check($sformatf("stall_hold%0d", k), pd[k], prev_d[k]);
      prev_st[k] = st;
      prev_d[k] = pd[k];
      fire = 0;
      if (pv[k] && p_tready) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) check($sformatf("unexpected_beat%0d", k), 64'(pv[k]), 64'(0));
        else begin
          if (k == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check($sformatf("p_tdata%0d", k), pd[k], e.d);
          check($sformatf("p_tlast%0d", k), 64'(pl[k]), 64'(e.l));
          fire = e.c;
        end
      end
      if (real_tvalid && cplx_tvalid && !st) begin
        if (k == 0) q0.push_back(exp_beat(real_tdata, cplx_tdata, real_tlast | cplx_tlast, 0, 0));
        else q1.push_back(exp_beat(real_tdata, cplx_tdata, real_tlast | cplx_tlast, 1, 1));
      end
      if (clear_count) mcnt[k] = '0;
      else if (fire && mcnt[k] != 16'hFFFF) mcnt[k] = mcnt[k] + 1'b1;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("clip_count%0d", k), 64'(cc[k]), 64'(mcnt[k]));
  endtask

  task automatic send(input logic [15:0] r, input logic [63:0] c, input logic l);
    real_tdata = r;
    cplx_tdata = c;
    real_tlast = l;
    cplx_tlast = 0;
    real_tvalid = 1;
    cplx_tvalid = 1;
    cycle();
    real_tvalid = 0;
    cplx_tvalid = 0;
    real_tlast = 0;
  endtask

  task automatic drain();
    p_tready = 1;
    real_tvalid = 0;
    cplx_tvalid = 0;
    for (int i = 0; i < 12 && (q0.size() != 0 || q1.size() != 0); i++) cycle();
    check("drain_q0", 64'(q0.size()), 64'(0));
    check("drain_q1", 64'(q1.size()), 64'(0));
  endtask

  function automatic logic [15:0] pick16();
    logic [15:0] v [6];
    v = '{16'h8000, 16'h7FFF, 16'h8001, 16'h0001, 16'hC000, 16'h4000};
    return $urandom_range(0, 1) != 0 ? v[$urandom_range(0, 5)] : 16'($urandom);
  endfunction

  initial begin
    reset_model();
    #3;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_p_tvalid%0d", k), 64'(pv[k]), 64'(0));
      check($sformatf("rst_p_tlast%0d", k), 64'(pl[k]), 64'(0));
      check($sformatf("rst_p_tdata%0d", k), pd[k], 64'(0));
      check($sformatf("rst_clip_count%0d", k), 64'(cc[k]), 64'(0));
    end
    #9 reset_n = 1;
    @(posedge clk);
    #1;

    send(16'h4000, {32'h0, 16'h2000, 16'hE000}, 0);
    check("lat_edge1", 64'(pv[1]), 64'(0));
    cycle();
    check("lat_edge2", 64'(pv[1]), 64'(0));
    cycle();
    check("lat_edge3", 64'(pv[1]), 64'(1));
    check("basic_lane0", 64'(pd[1][31:0]), 64'(32'h1000F000));
    cycle();
    check("basic_count", 64'(cc[1]), 64'(0));

    send(16'h8000, {32'h0, 16'h8000, 16'h8001}, 0);
    cycle();
    cycle();
    check("sat_lane0", 64'(pd[1][31:0]), 64'(32'h7FFF7FFF));
    check("wrap_lane0", 64'(pd[0][31:0]), 64'(32'h80007FFF));
    cycle();
    check("sat_count", 64'(cc[1]), 64'(1));
    check("wrap_count", 64'(cc[0]), 64'(0));

    send(16'h0001, {32'h0, 16'h4000, 16'h0}, 0);
    send(16'h0001, {32'h0, 16'h3FFF, 16'h0}, 0);
    send(16'h0001, {32'h0, 16'hC000, 16'h0}, 0);
    check("rnd_up", 64'(pd[1][31:16]), 64'(1));
    check("trunc_down", 64'(pd[0][31:16]), 64'(0));
    drain();

    send(16'h8000, {32'h0, 16'h8000, 16'h0}, 0);
    cycle();
    cycle();
    clear_count = 1;
    cycle();
    clear_count = 0;
    check("clear_wins", 64'(cc[1]), 64'(0));

    real_tvalid = 1;
    cplx_tvalid = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("no_xfer_rtready", 64'(rr[1]), 64'(0));
    end
    real_tvalid = 0;
    for (int i = 1; i <= 4; i++) send(16'($urandom), {$urandom, $urandom}, i == 4);
    drain();

    for (int i = 0; i < 40; i++) begin
      real_tdata = 16'(i * 37);
      cplx_tdata = {16'(i), 16'(-i), 16'(i * 3), 16'(i * 5)};
      real_tvalid = 1;
      cplx_tvalid = 1;
      p_tready = !(i >= 15 && i < 25);
      cycle();
    end
    drain();

    for (int i = 0; i < 400; i++) begin
      real_tdata = pick16();
      cplx_tdata = {pick16(), pick16(), pick16(), pick16()};
      real_tlast = $urandom_range(0, 7) == 0;
      cplx_tlast = $urandom_range(0, 7) == 0;
      real_tvalid = $urandom_range(0, 3) != 0;
      cplx_tvalid = $urandom_range(0, 3) != 0;
      p_tready = $urandom_range(0, 9) < 7;
      clear_count = $urandom_range(0, 31) == 0;
      cycle();
    end
    clear_count = 0;
    real_tlast = 0;
    cplx_tlast = 0;
    drain();

    p_tready = 1;
    for (int i = 0; i < 3; i++) send(16'h7FFF, {$urandom, $urandom}, 0);
    reset_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async_p_tvalid%0d", k), 64'(pv[k]), 64'(0));
      check($sformatf("async_p_tdata%0d", k), pd[k], 64'(0));
      check($sformatf("async_clip_count%0d", k), 64'(cc[k]), 64'(0));
    end
    reset_model();
    #1 reset_n = 1;
    for (int i = 0; i < 6; i++) cycle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
